// File: rtl/nibble_seq_adder_pkg.sv
// nibble_seq_pkg: shared types and constants for the nibble-serial adder.
//   NIBBLE_W : width of one adder slice
//   state_t  : controller states IDLE / RUN / DONE
package nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_seq_adder_slice.sv
// adder_slice4: 4-bit ripple adder slice.
//   a, b : slice operands
//   cin  : carry into bit 0
//   s    : slice sum
//   c3   : carry into bit 3 (for signed-overflow detection)
//   cout : carry out of bit 3
module adder_slice4
    import nibble_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                cout
);

    // Low three bits together; their carry-out is the carry into the top bit.
    logic [NIBBLE_W-1:0] w_lo;

    assign w_lo = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]} + {{(NIBBLE_W-1){1'b0}}, cin};
    assign c3   = w_lo[NIBBLE_W-1];
    assign s    = {a[NIBBLE_W-1] ^ b[NIBBLE_W-1] ^ c3, w_lo[NIBBLE_W-2:0]};
    assign cout = (a[NIBBLE_W-1] & b[NIBBLE_W-1]) | (c3 & (a[NIBBLE_W-1] ^ b[NIBBLE_W-1]));

endmodule

// File: rtl/nibble_seq_adder.sv
// nibble_seq_adder: adds two W-bit operands one nibble per cycle through a single 4-bit slice.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; operands sampled at the accepting edge
//   a, b, c_in           : operands and carry-in
//   sub                  : subtract request (only when NIBBLE_SEQ_ADDER_SUB_EN is defined)
//   out_valid / out_ready: result handshake; result held until accepted
//   sum, c_out, ovf      : result, unsigned carry (no-borrow when subtracting), signed overflow
// Define NIBBLE_SEQ_ADDER_SUB_EN to add the sub port and a-b support.
module nibble_seq_adder
    import nibble_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                       c_in,
`ifdef NIBBLE_SEQ_ADDER_SUB_EN
    input  logic                       sub,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                       c_out,
    output logic                       ovf
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    state_t              r_state;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;

    logic [NIBBLE_W-1:0] w_s;
    logic                w_c3;
    logic                w_cout;
    logic                w_last;

    assign w_last = r_idx == IW'(NIBBLES - 1);

    adder_slice4 u_slice (
        .a    (r_a[NIBBLE_W*r_idx +: NIBBLE_W]),
        .b    (r_b[NIBBLE_W*r_idx +: NIBBLE_W]),
        .cin  (r_carry),
        .s    (w_s),
        .c3   (w_c3),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a     <= a;
`ifdef NIBBLE_SEQ_ADDER_SUB_EN
                    // a - b computed as a + ~b + 1
                    r_b     <= sub ? ~b : b;
                    r_carry <= sub | c_in;
`else
                    r_b     <= b;
                    r_carry <= c_in;
`endif
                    r_idx   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_s;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_cout ^ w_c3;
                        r_state <= DONE;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_seq_adder.sv
// tb_nibble_seq_adder: directed self-checking bench for nibble_seq_adder (NIBBLES=4).
module tb_nibble_seq_adder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
`ifdef NIBBLE_SEQ_ADDER_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    nibble_seq_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef NIBBLE_SEQ_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One operation; out_ready held low for 'hold' DONE cycles with a competing in_valid.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                          input logic [15:0] es, input logic ec, input logic eo, input int hold);
        chk({tag, " ready"}, in_ready, 1);
        a = ta;
        b = tb_v;
        c_in = tc;
        in_valid = 1;
        tick();
        in_valid = 0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        c_in = 1;
        chk({tag, " busy"}, in_ready, 0);
        repeat (N - 1) tick();
        chk({tag, " early_valid"}, out_valid, 0);
        tick();
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " sum"}, sum, es);
        chk({tag, " c_out"}, c_out, ec);
        chk({tag, " ovf"}, ovf, eo);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1;
            tick();
            chk({tag, " hold_valid"}, out_valid, 1);
            chk({tag, " hold_sum"}, sum, es);
            chk({tag, " hold_ready"}, in_ready, 0);
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        out_ready = 0;
        c_in = 0;
        chk({tag, " released"}, out_valid, 0);
        chk({tag, " idle"}, in_ready, 1);
    endtask

    logic [15:0] q[$];
    logic [15:0] exp_v;
    int          last_t;
    int          results;
    logic        acc;

    initial begin
        rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        a = 0;
        b = 0;
        c_in = 0;
`ifdef NIBBLE_SEQ_ADDER_SUB_EN
        sub = 0;
`endif
        repeat (2) tick();
        chk("rst sum", sum, 0);
        chk("rst c_out", c_out, 0);
        chk("rst ovf", ovf, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        #2 rst_n = 1;
        tick();

        run_op("add", 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0, 0);
        run_op("wrap", 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 0);
        run_op("ovf", 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0);
        run_op("cin", 16'h00FF, 16'h0000, 1, 16'h0100, 0, 0, 0);
        run_op("bp", 16'h1234, 16'h0FFF, 0, 16'h2233, 0, 0, 3);

`ifdef NIBBLE_SEQ_ADDER_SUB_EN
        sub = 1;
        run_op("sub_neg", 16'h0005, 16'h0007, 0, 16'hFFFE, 0, 0, 0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1, 0);
        sub = 0;
`endif

        a = 16'hAAAA;
        b = 16'h5555;
        in_valid = 1;
        tick();
        in_valid = 0;
        repeat (2) tick();
        chk("midrun partial", sum[7:0], 8'hFF);
        #2 rst_n = 0;
        #1;
        chk("midrst sum", sum, 0);
        chk("midrst c_out", c_out, 0);
        chk("midrst ovf", ovf, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 1);
        #2 rst_n = 1;
        tick();
        run_op("after_rst", 16'h0001, 16'h0001, 0, 16'h0002, 0, 0, 0);

        out_ready = 1;
        tick();
        out_ready = 0;
        chk("stray out_ready valid", out_valid, 0);
        chk("stray out_ready ready", in_ready, 1);
        chk("stray out_ready sum", sum, 16'h0002);

        a = 16'h1111;
        b = 16'h0101;
        c_in = 0;
        in_valid = 1;
        out_ready = 1;
        last_t = -1;
        results = 0;
        for (int t = 1; t <= 20; t++) begin
            acc = in_ready;
            if (acc) begin
                exp_v = a + b;
                q.push_back(exp_v);
            end
            tick();
            if (acc) begin
                a = a + 16'h2222;
                b = b + 16'h0303;
            end
            if (out_valid) begin
                chk("b2b pending", q.size() > 0, 1);
                if (q.size() > 0) chk("b2b sum", sum, q.pop_front());
                if (last_t >= 0) chk("b2b period", t - last_t, N + 2);
                last_t = t;
                results++;
            end
        end
        in_valid = 0;
        out_ready = 0;
        chk("b2b count", results, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
